// File: rtl/xbox_pkg.sv
// xbox_pkg: shared types and constants for the XBOX memory arbiter slice.
//   line_t         : one memory line, 8 x 32-bit words (word 0 in bits [31:0])
//   be_t           : byte-enable for one line, bit b enables byte b
//   MEM_RD_LATENCY : cycles from xlr_mem_rd to valid xlr_mem_rdata
package xbox_pkg;
  localparam int unsigned MEM_RD_LATENCY = 1;
  localparam int unsigned LINE_WORDS     = 8;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  typedef logic [LINE_WORDS*4-1:0]     be_t;
endpackage

// File: rtl/xbox_rr_pick.sv
// xbox_rr_pick: purely combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : index of the last granted requester; search starts at ptr+1
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the granted requester
//   vld : a grant was issued
module xbox_rr_pick
  import xbox_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    // Visit ptr+1 .. ptr+N (mod N); the first active requester wins, which
    // leaves ptr itself as the lowest-priority candidate.
    for (int unsigned i = 1; i <= N; i++) begin
      int unsigned c;
      c = (32'(ptr) + i) % N;
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/xbox_mem_arb.sv
// xbox_mem_arb: round-robin arbiter sharing one XBOX memory between NUM_REQ
// requesters.
//   clk, rst_n        : single clock, asynchronous active-low reset
//   req_addr/wdata/be : per-requester address, write line, byte enables
//   req_rd/req_wr     : per-requester level requests, held until granted
//   req_gnt           : one-hot grant, combinational in the request cycle
//   req_rdata         : xlr_mem_rdata passed straight through
//   req_rvalid        : one-hot owner of req_rdata, MEM_RD_LATENCY after grant
//   xlr_mem_*         : memory master port (granted requester muxed out)
//   arb_gnt_cnt       : saturating per-requester grant counters, present only
//                       when XBOX_ARB_STATS_EN is defined
module xbox_mem_arb
  import xbox_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned LOG2_LINES_PER_MEM = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][7:0][31:0]                 req_wdata,
  input  logic [NUM_REQ-1:0][31:0]                      req_be,
  input  logic [NUM_REQ-1:0]                            req_rd,
  input  logic [NUM_REQ-1:0]                            req_wr,
  output logic [NUM_REQ-1:0]                            req_gnt,
  output logic [7:0][31:0]                              req_rdata,
  output logic [NUM_REQ-1:0]                            req_rvalid,
  output logic [LOG2_LINES_PER_MEM-1:0]                 xlr_mem_addr,
  output logic [7:0][31:0]                              xlr_mem_wdata,
  output logic [31:0]                                   xlr_mem_be,
  output logic                                          xlr_mem_rd,
  output logic                                          xlr_mem_wr,
  input  logic [7:0][31:0]                              xlr_mem_rdata
`ifdef XBOX_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]                      arb_gnt_cnt
`endif
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                     active;
  logic [NUM_REQ-1:0]                     gnt;
  logic [IW-1:0]                          gnt_idx;
  logic                                   gnt_vld;
  logic [IW-1:0]                          rr_ptr;
  logic [MEM_RD_LATENCY-1:0][NUM_REQ-1:0] rv_pipe;
  line_t                                  sel_wdata;
  be_t                                    sel_be;

  assign active = req_rd | req_wr;

  xbox_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (active),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  assign req_gnt = gnt;

  // Memory port mux; a simultaneous read+write on the winner is a write only.
  always_comb begin
    xlr_mem_addr = '0;
    sel_wdata    = '0;
    sel_be       = '0;
    xlr_mem_rd   = 1'b0;
    xlr_mem_wr   = 1'b0;
    if (gnt_vld) begin
      xlr_mem_addr = req_addr[gnt_idx];
      sel_wdata    = req_wdata[gnt_idx];
      sel_be       = req_be[gnt_idx];
      xlr_mem_wr   = req_wr[gnt_idx];
      xlr_mem_rd   = req_rd[gnt_idx] & ~req_wr[gnt_idx];
    end
  end

  assign xlr_mem_wdata = sel_wdata;
  assign xlr_mem_be    = sel_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IW'(NUM_REQ - 1);
    end else if (gnt_vld) begin
      rr_ptr <= gnt_idx;
    end
  end

  // Only the owner id travels down the pipe; the data itself is not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_pipe <= '0;
    end else begin
      rv_pipe[0] <= xlr_mem_rd ? gnt : '0;
      for (int unsigned i = 1; i < MEM_RD_LATENCY; i++) begin
        rv_pipe[i] <= rv_pipe[i-1];
      end
    end
  end

  assign req_rvalid = rv_pipe[MEM_RD_LATENCY-1];
  assign req_rdata  = xlr_mem_rdata;

`ifdef XBOX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_gnt_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (gnt[k] && (arb_gnt_cnt[k] != '1)) begin
          arb_gnt_cnt[k] <= arb_gnt_cnt[k] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_xbox_mem_arb.sv
// tb_xbox_mem_arb: self-checking bench for xbox_mem_arb (NUM_REQ=2, 16 lines).
// A behavioural memory answers the master port; a reference model tracks the
// round-robin order, a shadow copy of memory and the expected read returns.
module tb_xbox_mem_arb;
  import xbox_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned LINES = 16;

  logic                     clk;
  logic                     rst_n;
  logic [NR-1:0][AW-1:0]    req_addr;
  logic [NR-1:0][7:0][31:0] req_wdata;
  logic [NR-1:0][31:0]      req_be;
  logic [NR-1:0]            req_rd;
  logic [NR-1:0]            req_wr;
  logic [NR-1:0]            req_gnt;
  logic [7:0][31:0]         req_rdata;
  logic [NR-1:0]            req_rvalid;
  logic [AW-1:0]            xlr_mem_addr;
  logic [7:0][31:0]         xlr_mem_wdata;
  logic [31:0]              xlr_mem_be;
  logic                     xlr_mem_rd;
  logic                     xlr_mem_wr;
  logic [7:0][31:0]         xlr_mem_rdata;
`ifdef XBOX_ARB_STATS_EN
  logic [NR-1:0][15:0]      arb_gnt_cnt;
`endif

  xbox_mem_arb #(
    .NUM_REQ            (NR),
    .LOG2_LINES_PER_MEM (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .req_rd        (req_rd),
    .req_wr        (req_wr),
    .req_gnt       (req_gnt),
    .req_rdata     (req_rdata),
    .req_rvalid    (req_rvalid),
    .xlr_mem_addr  (xlr_mem_addr),
    .xlr_mem_wdata (xlr_mem_wdata),
    .xlr_mem_be    (xlr_mem_be),
    .xlr_mem_rd    (xlr_mem_rd),
    .xlr_mem_wr    (xlr_mem_wr),
    .xlr_mem_rdata (xlr_mem_rdata)
`ifdef XBOX_ARB_STATS_EN
    ,
    .arb_gnt_cnt   (arb_gnt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic line_t init_line(input int unsigned i);
    line_t l;
    for (int unsigned j = 0; j < 8; j++) begin
      if (i == 0) l[j] = 32'(j + 1);
      else        l[j] = 32'((i << 16) | j) ^ 32'h5A5A_0000;
    end
    return l;
  endfunction

  function automatic line_t apply_be(input line_t old, input line_t wd, input logic [31:0] be);
    logic [255:0] f_old;
    logic [255:0] f_new;
    f_old = old;
    f_new = wd;
    for (int unsigned b = 0; b < 32; b++) begin
      if (be[b]) f_old[b*8 +: 8] = f_new[b*8 +: 8];
    end
    return line_t'(f_old);
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int unsigned j = 0; j < 8; j++) l[j] = $urandom;
    return l;
  endfunction

  // Behavioural memory on the master port.
  logic  mem_load;
  line_t mem [LINES];
  line_t mem_rdata_q;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int unsigned i = 0; i < LINES; i++) mem[i] <= init_line(i);
    end else begin
      if (xlr_mem_wr) mem[xlr_mem_addr] <= apply_be(mem[xlr_mem_addr], xlr_mem_wdata, xlr_mem_be);
      if (xlr_mem_rd) mem_rdata_q <= mem[xlr_mem_addr];
    end
  end

  assign xlr_mem_rdata = mem_rdata_q;

  // Reference model and per-cycle compare, evaluated mid-cycle.
  int unsigned   last_k;
  logic [NR-1:0] erv;
  line_t         erdata;
  line_t         shadow [LINES];
  int unsigned   waitc [NR];
  logic [NR-1:0] model_gnt;
  logic [NR-1:0] m_act;
  logic [NR-1:0] m_gnt;
  logic          m_found;
  int unsigned   m_k;

  always @(negedge clk) begin
    if (mem_load) begin
      for (int unsigned i = 0; i < LINES; i++) shadow[i] = init_line(i);
    end
    if (!rst_n) begin
      chk("rvalid_in_reset", 256'(req_rvalid), 256'(0));
      last_k    = NR - 1;
      erv       = '0;
      model_gnt = '0;
      for (int unsigned i = 0; i < NR; i++) waitc[i] = 0;
    end else begin
      m_act   = req_rd | req_wr;
      m_gnt   = '0;
      m_found = 1'b0;
      m_k     = 0;
      for (int unsigned s = 1; s <= NR; s++) begin
        if (!m_found && m_act[(last_k + s) % NR]) begin
          m_found = 1'b1;
          m_k     = (last_k + s) % NR;
        end
      end
      if (m_found) m_gnt[m_k] = 1'b1;

      chk("gnt", 256'(req_gnt), 256'(m_gnt));
      chk("mem_addr",  256'(xlr_mem_addr),  m_found ? 256'(req_addr[m_k])  : 256'(0));
      chk("mem_wdata", 256'(xlr_mem_wdata), m_found ? 256'(req_wdata[m_k]) : 256'(0));
      chk("mem_be",    256'(xlr_mem_be),    m_found ? 256'(req_be[m_k])    : 256'(0));
      chk("mem_wr",    256'(xlr_mem_wr),    256'(m_found && req_wr[m_k]));
      chk("mem_rd",    256'(xlr_mem_rd),    256'(m_found && req_rd[m_k] && !req_wr[m_k]));
      chk("rvalid",    256'(req_rvalid),    256'(erv));
      if (erv != '0) chk("rdata", 256'(req_rdata), 256'(erdata));

      for (int unsigned i = 0; i < NR; i++) begin
        if (m_act[i] && !m_gnt[i]) waitc[i]++;
        else                       waitc[i] = 0;
        if (m_act[i]) chk("wait_bound", 256'(waitc[i] <= NR - 1), 256'(1));
      end

      erv = '0;
      if (m_found) begin
        last_k = m_k;
        if (req_wr[m_k]) begin
          shadow[req_addr[m_k]] = apply_be(shadow[req_addr[m_k]], req_wdata[m_k], req_be[m_k]);
        end else begin
          erv[m_k] = 1'b1;
          erdata   = shadow[req_addr[m_k]];
        end
      end
      model_gnt = m_gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_rd = '0;
    req_wr = '0;
  endtask

  logic [1:0]    gseq [4];
  line_t         lit_line;
  int unsigned   r;

  initial begin
    rst_n     = 1'b0;
    mem_load  = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    clear_reqs();
    tick();
    tick();
    mem_load = 1'b0;
    rst_n    = 1'b1;

    // Single read from requester 0 of line 0.
    req_rd[0]   = 1'b1;
    req_addr[0] = 4'h0;
    #2 chk("d1_gnt", 256'(req_gnt), 256'(2'b01));
    tick();
    clear_reqs();
    lit_line = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    #2 chk("d1_rvalid", 256'(req_rvalid), 256'(2'b01));
    chk("d1_rdata", 256'(req_rdata), 256'(lit_line));

    // Both reading for four cycles straight after reset.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    gseq = '{2'b01, 2'b10, 2'b01, 2'b10};
    req_rd      = 2'b11;
    req_addr[0] = 4'h2;
    req_addr[1] = 4'h2;
    for (int c = 0; c < 4; c++) begin
      #2 chk("d2_gnt", 256'(req_gnt), 256'(gseq[c]));
      if (c > 0) chk("d2_rvalid", 256'(req_rvalid), 256'(gseq[c-1]));
      tick();
    end
    clear_reqs();
    #2 chk("d2_rvalid_last", 256'(req_rvalid), 256'(2'b10));

    // Full-line write from requester 1, then read back by requester 0.
    tick();
    lit_line     = {32'd0, 32'd0, 32'd0, 32'd0, 32'd50, 32'd43, 32'd22, 32'd19};
    req_wr[1]    = 1'b1;
    req_addr[1]  = 4'h1;
    req_be[1]    = 32'hFFFF_FFFF;
    req_wdata[1] = lit_line;
    #2 chk("d3_wr", 256'(xlr_mem_wr), 256'(1));
    chk("d3_addr", 256'(xlr_mem_addr), 256'(4'h1));
    chk("d3_wdata", 256'(xlr_mem_wdata), 256'(lit_line));
    tick();
    clear_reqs();
    req_rd[0]   = 1'b1;
    req_addr[0] = 4'h1;
    #2 chk("d3_rd_gnt", 256'(req_gnt), 256'(2'b01));
    tick();
    clear_reqs();
    #2 chk("d3_rvalid", 256'(req_rvalid), 256'(2'b01));
    chk("d3_rdata", 256'(req_rdata), 256'(lit_line));

    // Read and write together on requester 0: write wins, no return.
    tick();
    req_rd[0]    = 1'b1;
    req_wr[0]    = 1'b1;
    req_addr[0]  = 4'h3;
    req_be[0]    = 32'h0000_00FF;
    req_wdata[0] = rand_line();
    #2 chk("d4_wr", 256'(xlr_mem_wr), 256'(1));
    chk("d4_rd", 256'(xlr_mem_rd), 256'(0));
    tick();
    clear_reqs();
    #2 chk("d4_rvalid", 256'(req_rvalid), 256'(2'b00));

    // Reset right after a read grant drops the return.
    tick();
    req_rd[1]   = 1'b1;
    req_addr[1] = 4'h5;
    #2 chk("d5_gnt", 256'(req_gnt), 256'(2'b10));
    tick();
    clear_reqs();
    rst_n = 1'b0;
    #2 chk("d5_rvalid_rst", 256'(req_rvalid), 256'(2'b00));
    tick();
    rst_n  = 1'b1;
    req_rd = 2'b11;
    #2 chk("d5_first_gnt", 256'(req_gnt), 256'(2'b01));
    chk("d5_rvalid_rel", 256'(req_rvalid), 256'(2'b00));
    tick();
    clear_reqs();

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(399) == 0) begin
        rst_n = 1'b0;
        clear_reqs();
        continue;
      end
      for (int k = 0; k < NR; k++) begin
        if (model_gnt[k] || !(req_rd[k] || req_wr[k])) begin
          r            = $urandom_range(9);
          req_rd[k]    = (r >= 3 && r < 6) || (r == 9);
          req_wr[k]    = (r >= 6);
          req_addr[k]  = AW'($urandom_range(LINES - 1));
          req_wdata[k] = rand_line();
          req_be[k]    = $urandom;
        end
      end
    end
    tick();
    clear_reqs();
    rst_n = 1'b1;
    tick();

`ifdef XBOX_ARB_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    req_rd      = 2'b10;
    req_addr[1] = 4'h0;
    repeat (70000) tick();
    clear_reqs();
    #2 chk("stats_cnt1", 256'(arb_gnt_cnt[1]), 256'(16'hFFFF));
    chk("stats_cnt0", 256'(arb_gnt_cnt[0]), 256'(16'h0000));
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
